// File: rtl/score_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// score_accumulator_pkg
// Shared definitions for the classifier output stage. The score accumulator and
// the downstream argmax block both import this package, so the score width,
// term width, class count and FSM encoding stay in one place.
//   DATA_WIDTH : width of one signed class score
//   IN_WIDTH   : width of one signed incoming product term
//   N_CLASSES  : number of class scores
//   IDX_WIDTH  : width of the class index carried with each term
//   acc_state_t: accumulator FSM encoding (ACCUM / SEND / WAIT)
// -----------------------------------------------------------------------------
package score_accumulator_pkg;

   localparam int DATA_WIDTH = 42;
   localparam int IN_WIDTH   = 30;
   localparam int N_CLASSES  = 10;
   localparam int IDX_WIDTH  = 4;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SEND  = 2'd1,
      ST_WAIT  = 2'd2
   } acc_state_t;

endpackage : score_accumulator_pkg

// File: rtl/score_accumulator_sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Combinational signed accumulate step: sign-extends a TERM_W-bit term to
// ACC_W bits, adds it to the running score and clamps the result to the
// representable range instead of wrapping.
// Ports:
//   acc  : current signed score (ACC_W bits)
//   term : signed product term (TERM_W bits)
//   sum  : saturated acc + term (ACC_W bits)
// -----------------------------------------------------------------------------
module sat_add #(
   parameter int ACC_W  = 42,
   parameter int TERM_W = 30
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [TERM_W-1:0] term,
   output logic [ACC_W-1:0]  sum
);

   logic [ACC_W-1:0] term_ext;
   logic [ACC_W:0]   wide;

   always_comb begin
      term_ext = {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};
      // One guard bit: the true sum always fits in ACC_W+1 bits, and it is out
      // of range exactly when the guard bit disagrees with the ACC_W sign bit.
      wide = {acc[ACC_W-1], acc} + {term_ext[ACC_W-1], term_ext};
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         // Guard bit holds the true sign: negative overflow clamps to the
         // most negative value, positive overflow to the most positive.
         sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         sum = wide[ACC_W-1:0];
      end
   end

endmodule : sat_add

// File: rtl/score_accumulator.sv
// -----------------------------------------------------------------------------
// score_accumulator
// Collects signed product terms into N_CLASSES saturating class scores. When
// the term flagged in_last is accepted the sample is complete: the scores are
// presented for one cycle (valid) and then held until the downstream argmax
// acknowledges with cmp_ready, at which point all scores clear for the next
// sample.
//
// Handshake: a term transfers on a rising edge where in_valid and in_ready are
// both 1. in_ready is 1 only in ACCUM; the upstream must hold in_valid and the
// term stable while in_ready is 0. cmp_ready is only looked at in WAIT.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : term present
//   in_ready   : term accepted this cycle (ACCUM)
//   in_data    : signed product term
//   in_idx     : target class index
//   in_last    : final term of the sample
//   layer_out  : packed scores, class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid      : one-cycle pulse, layer_out holds a complete sample
//   cmp_ready  : downstream has captured the scores
//   busy       : high in SEND and WAIT
//   idx_err    : sticky, a term with in_idx >= N_CLASSES was accepted
//   state      : current FSM state (debug observation)
// -----------------------------------------------------------------------------
module score_accumulator #(
   parameter int DATA_WIDTH = score_accumulator_pkg::DATA_WIDTH,
   parameter int IN_WIDTH   = score_accumulator_pkg::IN_WIDTH,
   parameter int N_CLASSES  = score_accumulator_pkg::N_CLASSES
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [IN_WIDTH-1:0]               in_data,
   input  logic [3:0]                        in_idx,
   input  logic                              in_last,
   output logic [DATA_WIDTH*N_CLASSES-1:0]   layer_out,
   output logic                              valid,
   input  logic                              cmp_ready,
   output logic                              busy,
   output logic                              idx_err,
   output score_accumulator_pkg::acc_state_t state
);

   import score_accumulator_pkg::*;

   acc_state_t state_q;
   acc_state_t state_d;

   logic [DATA_WIDTH-1:0] acc_q [N_CLASSES];
   logic [DATA_WIDTH-1:0] sel_acc;
   logic [DATA_WIDTH-1:0] sum;
   logic                  accept;
   logic                  idx_ok;
   logic                  release_sample;
   logic                  idx_err_q;

   assign accept         = in_valid && in_ready;
   assign idx_ok         = int'(in_idx) < N_CLASSES;
   assign release_sample = (state_q == ST_WAIT) && cmp_ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: if (accept && in_last) state_d = ST_SEND;
         ST_SEND:  state_d = ST_WAIT;
         ST_WAIT:  if (cmp_ready) state_d = ST_ACCUM;
         default:  state_d = ST_ACCUM;
      endcase
   end

   assign in_ready = (state_q == ST_ACCUM);
   assign valid    = (state_q == ST_SEND);
   assign busy     = (state_q == ST_SEND) || (state_q == ST_WAIT);
   assign state    = state_q;

   // ------------------------------------------------- shared adder datapath
   // A single adder serves every class: the addressed score is muxed in and
   // the result is written back only to that class. An out-of-range index
   // selects nothing and the write is suppressed below.
   always_comb begin
      sel_acc = '0;
      for (int k = 0; k < N_CLASSES; k++) begin
         if (int'(in_idx) == k) begin
            sel_acc = acc_q[k];
         end
      end
   end

   sat_add #(
      .ACC_W  (DATA_WIDTH),
      .TERM_W (IN_WIDTH)
   ) u_sat_add (
      .acc  (sel_acc),
      .term (in_data),
      .sum  (sum)
   );

   // ------------------------------------------------------- score registers
   // Scores only change in ACCUM (accept implies ACCUM), so layer_out is
   // frozen from SEND until the edge that leaves WAIT.
   always_ff @(posedge clk) begin
      if (rst || release_sample) begin
         for (int k = 0; k < N_CLASSES; k++) begin
            acc_q[k] <= '0;
         end
      end else if (accept && idx_ok) begin
         for (int k = 0; k < N_CLASSES; k++) begin
            if (int'(in_idx) == k) begin
               acc_q[k] <= sum;
            end
         end
      end
   end

   for (genvar k = 0; k < N_CLASSES; k++) begin : g_layer_out
      assign layer_out[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k];
   end

   // ----------------------------------------------------------- index error
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_err_q <= 1'b0;
      end else if (accept && !idx_ok) begin
         idx_err_q <= 1'b1;
      end
   end

   assign idx_err = idx_err_q;

endmodule : score_accumulator

// File: tb/tb_score_accumulator.sv
// -----------------------------------------------------------------------------
// tb_score_accumulator
// Scoreboarded bench for score_accumulator. A reference model of the class
// scores (64-bit arithmetic with explicit clamping) produces the expected
// packed vector when each in_last term is accepted; the monitor pops and
// compares it whenever the DUT raises valid. Scenario tasks add targeted checks
// for handshake, latency, saturation, index errors and reset.
// -----------------------------------------------------------------------------
module tb_score_accumulator;

   import score_accumulator_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int IW = IN_WIDTH;
   localparam int NC = N_CLASSES;
   localparam int LW = DW * NC;
   localparam longint SAT_MAX = (longint'(1) <<< (DW - 1)) - 1;
   localparam longint SAT_MIN = -(longint'(1) <<< (DW - 1));

   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_data   = '0;
   logic [3:0]    in_idx    = '0;
   logic          in_last   = 1'b0;
   logic [LW-1:0] layer_out;
   logic          valid;
   logic          cmp_ready = 1'b0;
   logic          busy;
   logic          idx_err;
   acc_state_t    state;

   score_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_idx    (in_idx),
      .in_last   (in_last),
      .layer_out (layer_out),
      .valid     (valid),
      .cmp_ready (cmp_ready),
      .busy      (busy),
      .idx_err   (idx_err),
      .state     (state)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int valid_count  = 0;

   // ------------------------------------------------------ reference model
   longint        model_acc [NC];
   logic [LW-1:0] exp_q [$];

   task automatic model_clear();
      for (int k = 0; k < NC; k++) model_acc[k] = 0;
   endtask

   task automatic model_add(input int idx, input longint data);
      longint s;
      if (idx < NC) begin
         s = model_acc[idx] + data;
         if (s > SAT_MAX) s = SAT_MAX;
         if (s < SAT_MIN) s = SAT_MIN;
         model_acc[idx] = s;
      end
   endtask

   function automatic logic [LW-1:0] model_vec();
      logic [LW-1:0] v;
      longint t;
      v = '0;
      for (int k = 0; k < NC; k++) begin
         t = model_acc[k];
         v[k*DW +: DW] = t[DW-1:0];
      end
      return v;
   endfunction

   function automatic int model_argmax();
      int best;
      best = 0;
      for (int k = 1; k < NC; k++) if (model_acc[k] > model_acc[best]) best = k;
      return best;
   endfunction

   // Argmax as the downstream block would compute it from layer_out.
   function automatic int vec_argmax(input logic [LW-1:0] v);
      int best;
      longint bv, cv;
      best = 0;
      bv = longint'($signed(v[0 +: DW]));
      for (int k = 1; k < NC; k++) begin
         cv = longint'($signed(v[k*DW +: DW]));
         if (cv > bv) begin
            best = k;
            bv = cv;
         end
      end
      return best;
   endfunction

   function automatic longint class_score(input logic [LW-1:0] v, input int k);
      return longint'($signed(v[k*DW +: DW]));
   endfunction

   // ------------------------------------------------------------ scoreboard
   always @(negedge clk) begin
      logic [LW-1:0] e;
      if (!rst && valid) begin
         valid_count++;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_spurious_valid: valid=1 with no sample expected");
         end else begin
            e = exp_q.pop_front();
            if (layer_out !== e) begin
               tests_failed++;
               $display("FAIL sb_layer_out: got %h expected %h", layer_out, e);
            end
         end
      end
   end

   // --------------------------------------------------------- driver tasks
   // All drivers start and end on a falling edge.
   task automatic send_term(input int idx, input longint data, input bit last);
      int n;
      in_valid = 1'b1;
      in_idx   = idx[3:0];
      in_data  = data[IW-1:0];
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL accept_timeout: in_ready=%0b required=1 within 50 cycles", in_ready);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      @(posedge clk);
      model_add(idx, data);
      if (last) exp_q.push_back(model_vec());
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Acknowledge the held sample after 'delay' more falling edges.
   task automatic release_sample(input int delay);
      repeat (delay) @(negedge clk);
      cmp_ready = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      cmp_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk);
      model_clear();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------ scenarios
   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 30'd77;
      cmp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      cmp_ready = 1'b0;
      model_clear();
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
      tests_run++;
      if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", valid); end
      tests_run++;
      if (busy !== 1'b0 || idx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: busy=%0b idx_err=%0b expected 0 0", busy, idx_err); end
      tests_run++;
      if (layer_out !== '0) begin tests_failed++; $display("FAIL reset_layer_out: got %h expected 0", layer_out); end
      tests_run++;
      if (state !== ST_ACCUM) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", state, ST_ACCUM); end
   endtask

   task automatic test_simple();
      send_term(0, 5, 1'b0);
      send_term(3, -7, 1'b0);
      send_term(3, 2, 1'b1);
      tests_run++;
      if (valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL simple_latency: valid=%0b in_ready=%0b busy=%0b expected 1 0 1", valid, in_ready, busy);
      end
      tests_run++;
      if (class_score(layer_out, 0) != 5 || class_score(layer_out, 3) != -5) begin
         tests_failed++;
         $display("FAIL simple_scores: class0=%0d class3=%0d expected 5 -5", class_score(layer_out, 0), class_score(layer_out, 3));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL simple_wait: cycle %0d valid=%0b in_ready=%0b busy=%0b expected 0 0 1", i, valid, in_ready, busy);
         end
      end
      release_sample(0);
      tests_run++;
      if (in_ready !== 1'b1 || layer_out !== '0) begin
         tests_failed++;
         $display("FAIL simple_release: in_ready=%0b layer_out=%h expected 1 and 0", in_ready, layer_out);
      end
   endtask

   task automatic test_bad_index();
      send_term(12, 100, 1'b0);
      tests_run++;
      if (idx_err !== 1'b1 || layer_out !== '0) begin
         tests_failed++;
         $display("FAIL bad_idx_set: idx_err=%0b layer_out=%h expected 1 and 0", idx_err, layer_out);
      end
      send_term(2, 4, 1'b1);
      release_sample(1);
      send_term(5, $urandom_range(1, 50), 1'b1);
      tests_run++;
      if (idx_err !== 1'b1) begin tests_failed++; $display("FAIL bad_idx_sticky: got %0b expected 1", idx_err); end
      release_sample(1);
   endtask

   task automatic test_hold();
      logic [LW-1:0] snap;
      send_term(4, -3, 1'b0);
      send_term(9, 11, 1'b1);
      snap = model_vec();
      // Present a term that must not be taken while the sample is held.
      in_valid = 1'b1;
      in_idx   = 4'd2;
      in_data  = 30'd9;
      in_last  = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         tests_run++;
         if (in_ready !== 1'b0 || layer_out !== snap) begin
            tests_failed++;
            $display("FAIL hold_stable: cycle %0d in_ready=%0b layer_out=%h expected 0 and %h", i, in_ready, layer_out, snap);
         end
      end
      cmp_ready = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      cmp_ready = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || layer_out !== '0) begin
         tests_failed++;
         $display("FAIL hold_release: in_ready=%0b layer_out=%h expected 1 and 0", in_ready, layer_out);
      end
      @(posedge clk);
      model_add(2, 9);
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (layer_out !== model_vec()) begin
         tests_failed++;
         $display("FAIL hold_first_term: got %h expected %h", layer_out, model_vec());
      end
      send_term(2, 1, 1'b1);
      release_sample(1);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 4100; i++) send_term(1, (longint'(1) <<< 29) - 1, 1'b0);
      send_term(1, 0, 1'b1);
      tests_run++;
      if (class_score(layer_out, 1) != SAT_MAX) begin
         tests_failed++;
         $display("FAIL sat_pos: got %0d expected %0d", class_score(layer_out, 1), SAT_MAX);
      end
      release_sample(1);
      for (int i = 0; i < 4100; i++) send_term(1, -(longint'(1) <<< 29), 1'b0);
      send_term(1, 0, 1'b1);
      tests_run++;
      if (class_score(layer_out, 1) != SAT_MIN) begin
         tests_failed++;
         $display("FAIL sat_neg: got %0d expected %0d", class_score(layer_out, 1), SAT_MIN);
      end
      release_sample(1);
   endtask

   task automatic test_reset_mid();
      int vc;
      send_term(0, 3, 1'b0);
      send_term(6, -8, 1'b0);
      send_term(6, 20, 1'b0);
      apply_reset();
      tests_run++;
      if (layer_out !== '0 || valid !== 1'b0 || in_ready !== 1'b1 || idx_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_accum: layer_out=%h valid=%0b in_ready=%0b idx_err=%0b expected 0 0 1 0", layer_out, valid, in_ready, idx_err);
      end
      send_term(1, 1, 1'b1);
      @(negedge clk);
      apply_reset();
      tests_run++;
      if (layer_out !== '0 || valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_wait: layer_out=%h valid=%0b in_ready=%0b busy=%0b expected 0 0 1 0", layer_out, valid, in_ready, busy);
      end
      vc = valid_count;
      repeat (4) @(negedge clk);
      tests_run++;
      if (valid_count != vc) begin
         tests_failed++;
         $display("FAIL rst_no_valid: valid pulses=%0d expected 0", valid_count - vc);
      end
   endtask

   task automatic test_back_to_back();
      int pred;
      for (int s = 0; s < 3; s++) begin
         // Two terms per class; winner class gets a large positive score.
         for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NC; k++) begin
               if (k == ((s == 1) ? 2 : 7)) send_term(k, 20 + s, (r == 1) && (k == NC - 1));
               else send_term(k, -longint'($urandom_range(1, 40)), (r == 1) && (k == NC - 1));
            end
         end
         pred = vec_argmax(layer_out);
         tests_run++;
         if (valid !== 1'b1 || pred != model_argmax()) begin
            tests_failed++;
            $display("FAIL e2e_pred: sample %0d valid=%0b prediction=%0d expected %0d", s, valid, pred, model_argmax());
         end
         release_sample(2);
         tests_run++;
         if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL e2e_ready: sample %0d in_ready=%0b expected 1", s, in_ready); end
      end
   endtask

   // ------------------------------------------------------------- watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ main flow
   initial begin
      model_clear();
      test_reset();
      test_simple();
      test_bad_index();
      test_hold();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      repeat (4) @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_leftover: %0d samples pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_score_accumulator
